// File: rtl/pid_pkg.sv
// Shared types and constants for the PID controller slice.
// No logic; compile-time only.
// No flow control.
//
// Contents: FSM state enum, datapath widths, sign-extension helper.
package pid_pkg;

   localparam int ACCW    = 24;   // accumulator width (signed)
   localparam int EW      = 9;    // error width (signed)
   localparam int DW      = 10;   // derivative difference width (signed)
   localparam int OUT_MAX = 255;  // top of the unsigned 8-bit command range
   localparam int DATW    = 8;    // setpoint / measure / command width
   localparam int GAINW   = 4;    // gain width (unsigned)

   typedef enum logic [2:0] {
      IDLE,
      ERR,
      MP,
      MI,
      MD,
      OUT
   } state_t;

   // Widen a small signed operand to the multiplier/accumulator width.
   function automatic logic signed [ACCW-1:0] sext_acc(input logic signed [DW-1:0] v);
      return {{(ACCW-DW){v[DW-1]}}, v};
   endfunction

endpackage

// File: rtl/pid_if.sv
// Sample-in / command-out bundle between a sample source and pid_core.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input side; output side is a pulse with no ready.
//
// master: drives sample and gains, observes handshake and command.
// slave : pid_core side.
interface pid_if;
   import pid_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATW-1:0]   setpoint;
   logic [DATW-1:0]   measure;
   logic [GAINW-1:0]  kp;
   logic [GAINW-1:0]  ki;
   logic [GAINW-1:0]  kd;
   logic              clr_integ;
   logic [DATW-1:0]   u;
   logic              out_valid;
   logic              sat_hi;
   logic              sat_lo;

   modport master (
      output in_valid, setpoint, measure, kp, ki, kd, clr_integ,
      input  in_ready, u, out_valid, sat_hi, sat_lo
   );

   modport slave (
      input  in_valid, setpoint, measure, kp, ki, kd, clr_integ,
      output in_ready, u, out_valid, sat_hi, sat_lo
   );

endinterface

// File: rtl/pid_sat.sv
// Signed saturator: clamps a signed value into [P_MIN, P_MAX] and narrows it.
// Latency: combinational.
// Backpressure: none.
//
// i_din    : signed input, IN_W bits
// o_dout   : clamped value, low OUT_W bits (two's complement or unsigned per range)
// o_sat_hi : input was above P_MAX
// o_sat_lo : input was below P_MIN
module pid_sat #(
   parameter int     IN_W  = 17,
   parameter int     OUT_W = 16,
   parameter longint P_MIN = -32768,
   parameter longint P_MAX = 32767
) (
   input  logic signed [IN_W-1:0]  i_din,
   output logic        [OUT_W-1:0] o_dout,
   output logic                    o_sat_hi,
   output logic                    o_sat_lo
);

   logic signed [63:0] w_din;

   assign w_din    = 64'(i_din);
   assign o_sat_hi = (w_din > P_MAX);
   assign o_sat_lo = (w_din < P_MIN);

   // In range, the low bits already hold the correct narrowed value.
   assign o_dout = o_sat_hi ? OUT_W'(P_MAX) :
                   o_sat_lo ? OUT_W'(P_MIN) :
                              i_din[OUT_W-1:0];

endmodule

// File: rtl/pid_core.sv
// PID controller: one 8-bit command per accepted setpoint/measure sample.
// Latency: out_valid pulses the cycle after the 5th edge following accept; 1 sample / 6 cycles.
// Backpressure: in_ready only in IDLE; no output backpressure, out_valid is a single-cycle pulse.
//
// clk, rst_n : clock, synchronous active-low reset
// bus        : pid_if.slave (sample, gains, clr_integ in; in_ready, u, out_valid, sat flags out)
module pid_core
   import pid_pkg::*;
#(
   parameter int IW   = 16,   // integrator width (signed, saturating)
   parameter int ISH  = 4,    // right shift on ki*integ
   parameter int OSH  = 2,    // right shift on P+I+D
   parameter int BIAS = 128   // output offset
) (
   input  logic clk,
   input  logic rst_n,
   pid_if.slave bus
);

   state_t                   r_state;
   state_t                   w_next;
   logic                     w_in_ready;

   logic [DATW-1:0]          r_sp;
   logic [DATW-1:0]          r_meas;
   logic [GAINW-1:0]         r_kp;
   logic [GAINW-1:0]         r_ki;
   logic [GAINW-1:0]         r_kd;
   logic signed [EW-1:0]     r_eprev;
   logic signed [DW-1:0]     r_diff;
   logic signed [IW-1:0]     r_integ;
   logic signed [ACCW-1:0]   r_acc;
   logic [DATW-1:0]          r_u;
   logic                     r_out_valid;
   logic                     r_sat_hi;
   logic                     r_sat_lo;

   logic signed [EW-1:0]     w_e;
   logic signed [DW-1:0]     w_diff;
   logic signed [IW:0]       w_isum;
   logic [IW-1:0]            w_integ_sat;
   logic                     w_isat_hi_unused;
   logic                     w_isat_lo_unused;
   logic                     w_iwind;

   logic [GAINW-1:0]         w_gain;
   logic signed [ACCW-1:0]   w_mul_b;
   logic signed [ACCW-1:0]   w_prod;
   logic signed [ACCW-1:0]   w_term;

   logic signed [ACCW-1:0]   w_acc_sh;
   logic signed [ACCW:0]     w_s;
   logic [DATW-1:0]          w_u;
   logic                     w_out_hi;
   logic                     w_out_lo;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_in_ready = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_next = ERR;
         end
         ERR:     w_next = MP;
         MP:      w_next = MI;
         MI:      w_next = MD;
         MD:      w_next = OUT;
         OUT:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // ---------------- error, derivative, integrator ----------------
   assign w_e    = $signed({1'b0, r_sp}) - $signed({1'b0, r_meas});
   assign w_diff = DW'(w_e) - DW'(r_eprev);
   assign w_isum = (IW+1)'(r_integ) + (IW+1)'(w_e);

   // Anti-windup: stop integrating further into the rail the output is stuck on.
   assign w_iwind = (r_sat_hi && (w_e > 0)) || (r_sat_lo && (w_e < 0));

   pid_sat #(
      .IN_W  (IW + 1),
      .OUT_W (IW),
      .P_MIN (-(longint'(1) <<< (IW - 1))),
      .P_MAX ((longint'(1) <<< (IW - 1)) - 1)
   ) u_integ_sat (
      .i_din    (w_isum),
      .o_dout   (w_integ_sat),
      .o_sat_hi (w_isat_hi_unused),
      .o_sat_lo (w_isat_lo_unused)
   );

   // ---------------- shared multiplier ----------------
   // After ERR, r_eprev already holds the current sample's error, so MP reads it directly.
   always_comb begin
      w_gain  = '0;
      w_mul_b = '0;
      case (r_state)
         MP: begin
            w_gain  = r_kp;
            w_mul_b = sext_acc(DW'(r_eprev));
         end
         MI: begin
            w_gain  = r_ki;
            w_mul_b = ACCW'(r_integ);
         end
         MD: begin
            w_gain  = r_kd;
            w_mul_b = sext_acc(r_diff);
         end
         default: ;
      endcase
   end

   // Gain is zero-extended so it is always a non-negative signed factor.
   assign w_prod = $signed({{(ACCW-GAINW){1'b0}}, w_gain}) * w_mul_b;
   assign w_term = (r_state == MI) ? (w_prod >>> ISH) : w_prod;

   // ---------------- output clamp ----------------
   assign w_acc_sh = r_acc >>> OSH;
   assign w_s      = (ACCW+1)'(w_acc_sh) + (ACCW+1)'(BIAS);

   pid_sat #(
      .IN_W  (ACCW + 1),
      .OUT_W (DATW),
      .P_MIN (0),
      .P_MAX (OUT_MAX)
   ) u_out_sat (
      .i_din    (w_s),
      .o_dout   (w_u),
      .o_sat_hi (w_out_hi),
      .o_sat_lo (w_out_lo)
   );

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sp        <= '0;
         r_meas      <= '0;
         r_kp        <= '0;
         r_ki        <= '0;
         r_kd        <= '0;
         r_eprev     <= '0;
         r_diff      <= '0;
         r_integ     <= '0;
         r_acc       <= '0;
         r_u         <= '0;
         r_out_valid <= 1'b0;
         r_sat_hi    <= 1'b0;
         r_sat_lo    <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               // The clear lands before ERR, so a sample accepted together
               // with clr_integ integrates from zero.
               if (bus.clr_integ) begin
                  r_integ <= '0;
                  r_eprev <= '0;
               end
               if (bus.in_valid) begin
                  r_sp   <= bus.setpoint;
                  r_meas <= bus.measure;
                  r_kp   <= bus.kp;
                  r_ki   <= bus.ki;
                  r_kd   <= bus.kd;
               end
            end
            ERR: begin
               r_diff  <= w_diff;
               r_eprev <= w_e;
               r_acc   <= '0;
               if (!w_iwind) r_integ <= $signed(w_integ_sat);
            end
            MP, MI, MD: begin
               r_acc <= r_acc + w_term;
            end
            OUT: begin
               r_u         <= w_u;
               r_sat_hi    <= w_out_hi;
               r_sat_lo    <= w_out_lo;
               r_out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.u         = r_u;
   assign bus.out_valid = r_out_valid;
   assign bus.sat_hi    = r_sat_hi;
   assign bus.sat_lo    = r_sat_lo;

endmodule

// File: tb/tb_pid_core.sv
// Directed bench for pid_core with a queue-based scoreboard.
// Stimulus pushes the hand-computed command per sample; a monitor pops on out_valid.
// Handshake timing, anti-windup and mid-sample reset are checked inline.
module tb_pid_core;

   typedef struct {
      int u;
      int hi;
      int lo;
      int tag;
   } exp_t;

   logic clk;
   logic rst_n;
   pid_if bus();

   exp_t expq[$];
   exp_t mon_x;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   tag   = 0;

   pid_core #(
      .IW   (16),
      .ISH  (4),
      .OSH  (2),
      .BIAS (128)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor, sampling away from the active edge.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got out_valid=1 u=%0d, required no output", bus.u);
         end else begin
            mon_x = expq.pop_front();
            chk($sformatf("u_sample%0d", mon_x.tag), int'(bus.u), mon_x.u);
            chk($sformatf("sat_hi_sample%0d", mon_x.tag), int'(bus.sat_hi), mon_x.hi);
            chk($sformatf("sat_lo_sample%0d", mon_x.tag), int'(bus.sat_lo), mon_x.lo);
         end
      end
   end

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("in_ready_timeout", 0, 1);
   endtask

   task automatic wait_ov();
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("out_valid_timeout", 0, 1);
   endtask

   task automatic drive(input int sp, input int ms, input int p, input int i, input int d,
                        input bit clr);
      bus.setpoint  = 8'(sp);
      bus.measure   = 8'(ms);
      bus.kp        = 4'(p);
      bus.ki        = 4'(i);
      bus.kd        = 4'(d);
      bus.clr_integ = clr;
      bus.in_valid  = 1'b1;
   endtask

   task automatic expect_out(input int eu, input int eh, input int el);
      exp_t x;
      tag++;
      x.u = eu; x.hi = eh; x.lo = el; x.tag = tag;
      expq.push_back(x);
   endtask

   // Offer one sample, record its expected command, wait for the result pulse.
   task automatic send(input int sp, input int ms, input int p, input int i, input int d,
                       input bit clr, input int eu, input int eh, input int el);
      wait_idle();
      drive(sp, ms, p, i, d, clr);
      expect_out(eu, eh, el);
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.clr_integ = 1'b0;
      wait_ov();
   endtask

   initial begin
      bit ov_seen;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.setpoint  = '0;
      bus.measure   = '0;
      bus.kp        = '0;
      bus.ki        = '0;
      bus.kd        = '0;
      bus.clr_integ = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_u", int'(bus.u), 0);
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_sat", int'({bus.sat_hi, bus.sat_lo}), 0);
      chk("reset_in_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Zero error with all gains: only the bias reaches the output; check timing.
      wait_idle();
      drive(100, 100, 5, 5, 5, 1'b0);
      expect_out(128, 0, 0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("busy_in_ready_T%0d", k), int'(bus.in_ready), 0);
         chk($sformatf("busy_out_valid_T%0d", k), int'(bus.out_valid), 0);
      end
      @(negedge clk);
      chk("pulse_out_valid", int'(bus.out_valid), 1);
      chk("pulse_in_ready", int'(bus.in_ready), 1);
      @(negedge clk);
      chk("pulse_one_cycle", int'(bus.out_valid), 0);

      // Proportional: in range, then both clamp rails.
      send(120, 100, 4, 0, 0, 1'b1, 148, 0, 0);
      send(255, 0, 15, 0, 0, 1'b0, 255, 1, 0);
      send(0, 255, 15, 0, 0, 1'b0, 0, 0, 1);

      // Integrator steps: integ 16,32,48,64 -> I 8,16,24,32.
      send(116, 100, 0, 8, 0, 1'b1, 130, 0, 0);
      send(116, 100, 0, 8, 0, 1'b0, 132, 0, 0);
      send(116, 100, 0, 8, 0, 1'b0, 134, 0, 0);
      send(116, 100, 0, 8, 0, 1'b0, 136, 0, 0);
      // Clear in IDLE without a sample.
      wait_idle();
      bus.clr_integ = 1'b1;
      @(posedge clk);
      #1 bus.clr_integ = 1'b0;
      send(116, 100, 0, 8, 0, 1'b0, 130, 0, 0);
      // Clear together with accept (integ was 16 beforehand).
      send(116, 100, 0, 8, 0, 1'b1, 130, 0, 0);

      // Derivative: e=0; then diff=8 -> D=16; then diff=0.
      send(50, 50, 0, 0, 2, 1'b1, 128, 0, 0);
      send(50, 42, 0, 0, 2, 1'b0, 132, 0, 0);
      send(50, 42, 0, 0, 2, 1'b0, 128, 0, 0);

      // Anti-windup: integ 255,510,765 gives u 187,247,clamped.
      send(255, 0, 0, 15, 0, 1'b1, 187, 0, 0);
      send(255, 0, 0, 15, 0, 1'b0, 247, 0, 0);
      send(255, 0, 0, 15, 0, 1'b0, 255, 1, 0);
      chk("integ_at_sat", int'(dut.r_integ), 765);
      send(255, 0, 0, 15, 0, 1'b0, 255, 1, 0);
      chk("integ_held", int'(dut.r_integ), 765);
      send(0, 10, 0, 15, 0, 1'b0, 255, 1, 0);
      chk("integ_unwind", int'(dut.r_integ), 755);

      // Reset in MI: sample aborted, state cleared.
      wait_idle();
      drive(200, 100, 1, 0, 0, 1'b0);
      @(posedge clk);              // T
      #1 bus.in_valid = 1'b0;
      @(posedge clk);              // T+1
      @(posedge clk);              // T+2
      #1 rst_n = 1'b0;
      @(posedge clk);              // T+3
      #1 rst_n = 1'b1;
      ov_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.out_valid) ov_seen = 1;
      end
      chk("abort_no_out_valid", int'(ov_seen), 0);
      chk("abort_u", int'(bus.u), 0);
      chk("abort_in_ready", int'(bus.in_ready), 1);
      chk("abort_sat_hi", int'(bus.sat_hi), 0);
      send(77, 77, 0, 15, 0, 1'b0, 128, 0, 0);

      repeat (5) @(negedge clk);
      chk("queue_drained", expq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
